// File: rtl/dp_pkg.sv
// Shared types for the Simple RISC Machine control path: FSM states,
// instruction encodings, writeback-select codes and the control word.
package dp_pkg;

  typedef enum logic [2:0] {
    WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM
  } state_t;

  typedef enum logic [1:0] {
    VSEL_C, VSEL_PC, VSEL_IMM8, VSEL_MDATA
  } vsel_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_SH  = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  typedef struct packed {
    logic       idle;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    vsel_t      vsel;
    logic [1:0] aluop;
  } ctl_t;

  localparam ctl_t CTL_ZERO = '{idle: 1'b0, readnum: 3'd0, writenum: 3'd0,
                                write: 1'b0, loada: 1'b0, loadb: 1'b0,
                                loadc: 1'b0, loads: 1'b0, asel: 1'b0,
                                vsel: VSEL_C, aluop: 2'b00};

  localparam ctl_t CTL_IDLE = '{idle: 1'b1, readnum: 3'd0, writenum: 3'd0,
                                write: 1'b0, loada: 1'b0, loadb: 1'b0,
                                loadc: 1'b0, loads: 1'b0, asel: 1'b0,
                                vsel: VSEL_C, aluop: 2'b00};

  function automatic logic [15:0] sext8(input logic [7:0] imm);
    return {{8{imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits the IR into register/shift fields,
// sign-extends the 8-bit immediate and classifies the instruction (one-hot).
module instr_decoder
  import dp_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [1:0]  o_op,
  output logic [2:0]  o_rn,
  output logic [2:0]  o_rd,
  output logic [2:0]  o_rm,
  output logic [1:0]  o_sh,
  output logic [15:0] o_sximm8,
  output logic        o_mov_imm,
  output logic        o_mov_sh,
  output logic        o_add,
  output logic        o_cmp,
  output logic        o_and,
  output logic        o_mvn,
  output logic        o_illegal
);

  logic [2:0] w_opcode;
  logic       w_is_mov;
  logic       w_is_alu;

  assign w_opcode = i_ir[15:13];
  assign o_op     = i_ir[12:11];
  assign o_rn     = i_ir[10:8];
  assign o_rd     = i_ir[7:5];
  assign o_sh     = i_ir[4:3];
  assign o_rm     = i_ir[2:0];
  assign o_sximm8 = sext8(i_ir[7:0]);

  assign w_is_mov = (w_opcode == OPC_MOV);
  assign w_is_alu = (w_opcode == OPC_ALU);

  assign o_mov_imm = w_is_mov && (o_op == OP_MOV_IMM);
  assign o_mov_sh  = w_is_mov && (o_op == OP_MOV_SH);
  assign o_add     = w_is_alu && (o_op == OP_ADD);
  assign o_cmp     = w_is_alu && (o_op == OP_CMP);
  assign o_and     = w_is_alu && (o_op == OP_AND);
  assign o_mvn     = w_is_alu && (o_op == OP_MVN);

  // MOV with op 01/11 and every other opcode have no defined behaviour
  assign o_illegal = ~(o_mov_imm | o_mov_sh | w_is_alu);

endmodule

// File: rtl/dp_sequencer.sv
// Instruction register and multi-cycle control FSM for the Simple RISC Machine
// datapath; outputs are registered Moore decodes of the FSM state.
module dp_sequencer
  import dp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic        w,
  output logic        illegal
);

  state_t      r_state;
  state_t      w_nxt;
  logic [15:0] r_ir;
  logic        r_illegal;
  ctl_t        r_ctl;
  ctl_t        w_ctl_nxt;

  logic [1:0]  w_op;
  logic [2:0]  w_rn;
  logic [2:0]  w_rd;
  logic [2:0]  w_rm;
  logic [1:0]  w_sh;
  logic [15:0] w_sximm8;
  logic        w_mov_imm;
  logic        w_mov_sh;
  logic        w_add;
  logic        w_cmp;
  logic        w_and;
  logic        w_mvn;
  logic        w_illegal;

  instr_decoder u_dec (
    .i_ir      (r_ir),
    .o_op      (w_op),
    .o_rn      (w_rn),
    .o_rd      (w_rd),
    .o_rm      (w_rm),
    .o_sh      (w_sh),
    .o_sximm8  (w_sximm8),
    .o_mov_imm (w_mov_imm),
    .o_mov_sh  (w_mov_sh),
    .o_add     (w_add),
    .o_cmp     (w_cmp),
    .o_and     (w_and),
    .o_mvn     (w_mvn),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      WAIT:   if (s) w_nxt = DECODE;
      DECODE: begin
        if (w_mov_imm)                   w_nxt = WR_IMM;
        else if (w_add || w_cmp || w_and) w_nxt = GET_A;
        else if (w_mov_sh || w_mvn)      w_nxt = GET_B;
        else                             w_nxt = WAIT;
      end
      GET_A:  w_nxt = GET_B;
      GET_B:  w_nxt = EXEC;
      EXEC:   w_nxt = w_cmp ? WAIT : WR_REG;
      WR_REG: w_nxt = WAIT;
      WR_IMM: w_nxt = WAIT;
      default: w_nxt = WAIT;
    endcase
  end

  // Outputs for the state being entered. Using the current IR decode is safe:
  // the IR only changes on entry to WAIT/DECODE, whose outputs ignore it.
  always_comb begin
    w_ctl_nxt = CTL_ZERO;
    case (w_nxt)
      WAIT:   w_ctl_nxt.idle = 1'b1;
      GET_A: begin
        w_ctl_nxt.readnum = w_rn;
        w_ctl_nxt.loada   = 1'b1;
      end
      GET_B: begin
        w_ctl_nxt.readnum = w_rm;
        w_ctl_nxt.loadb   = 1'b1;
      end
      EXEC: begin
        w_ctl_nxt.aluop = w_mov_sh ? 2'b00 : w_op;
        w_ctl_nxt.asel  = w_mov_sh;
        w_ctl_nxt.loads = w_cmp;
        w_ctl_nxt.loadc = ~w_cmp;
      end
      WR_REG: begin
        w_ctl_nxt.writenum = w_rd;
        w_ctl_nxt.vsel     = VSEL_C;
        w_ctl_nxt.write    = 1'b1;
      end
      WR_IMM: begin
        w_ctl_nxt.writenum = w_rn;
        w_ctl_nxt.vsel     = VSEL_IMM8;
        w_ctl_nxt.write    = 1'b1;
      end
      default: w_ctl_nxt = CTL_ZERO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= WAIT;
      r_ir      <= '0;
      r_illegal <= 1'b0;
      r_ctl     <= CTL_IDLE;
    end else begin
      r_state <= w_nxt;
      r_ctl   <= w_ctl_nxt;
      if (r_state == WAIT && load) r_ir <= in;
      if (r_state == DECODE) r_illegal <= w_illegal;
    end
  end

  // Strobes are gated by reset so an in-flight instruction cannot write
  // during the reset cycle.
  assign write    = r_ctl.write & reset;
  assign loada    = r_ctl.loada & reset;
  assign loadb    = r_ctl.loadb & reset;
  assign loadc    = r_ctl.loadc & reset;
  assign loads    = r_ctl.loads & reset;
  assign readnum  = r_ctl.readnum;
  assign writenum = r_ctl.writenum;
  assign asel     = r_ctl.asel;
  assign bsel     = 1'b0;
  assign vsel     = r_ctl.vsel;
  assign ALUop    = r_ctl.aluop;
  assign w        = r_ctl.idle;
  assign shift    = w_sh;
  assign sximm8   = w_sximm8;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_dp_sequencer.sv
// Scoreboard bench for dp_sequencer: directed instructions push expected control
// events (strobe cycles and w returning high); a negedge monitor pops and compares.
module tb_dp_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        load;
  logic        s;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic        w;
  logic        illegal;

  dp_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .in       (instr),
    .load     (load),
    .s        (s),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
    .w        (w),
    .illegal  (illegal)
  );

  typedef struct {
    int          cyc;
    logic [36:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {w, illegal, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop, sximm8}
  function automatic logic [36:0] ev(input int wi, input int ill, input int rn, input int wn,
                                     input int wr, input int la, input int lb, input int lc,
                                     input int ls, input int as, input int vs, input int sh,
                                     input int alu, input logic [15:0] sx);
    return {wi[0], ill[0], rn[2:0], wn[2:0], wr[0], la[0], lb[0], lc[0], ls[0],
            as[0], 1'b0, vs[1:0], sh[1:0], alu[1:0], sx};
  endfunction

  function automatic logic [36:0] dn(input int ill, input int sh, input logic [15:0] sx);
    return ev(1, ill, 0, 0, 0, 0, 0, 0, 0, 0, 0, sh, 0, sx);
  endfunction

  task automatic push(input int c, input string nm, input logic [36:0] v);
    exp_t x;
    x.cyc = c;
    x.v   = v;
    x.nm  = nm;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic begin_run(input logic [15:0] ins);
    instr = ins;
    load  = 1'b1;
    s     = 1'b1;
    e     = cyc + 1;
  endtask

  task automatic end_issue();
    tick();
    load = 1'b0;
    s    = 1'b0;
  endtask

  // Monitor: an event is any strobe or w rising from 0 to 1.
  initial begin
    logic        w_prev;
    logic        strobe;
    logic        rise;
    logic [36:0] obs;
    exp_t        x;
    w_prev = 1'b0;
    forever begin
      @(negedge clk);
      strobe = (write === 1'b1) || (loada === 1'b1) || (loadb === 1'b1) ||
               (loadc === 1'b1) || (loads === 1'b1);
      rise   = (w === 1'b1) && !w_prev;
      w_prev = (w === 1'b1);
      if (strobe || rise) begin
        obs = {w, illegal, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm8};
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d got=%h required=none", cyc, obs);
        end else begin
          x = q.pop_front();
          if (cyc != x.cyc) begin
            failures++;
            $display("FAIL %s_cycle got=%0d required=%0d", x.nm, cyc, x.cyc);
          end
          checks++;
          if (obs !== x.v) begin
            failures++;
            $display("FAIL %s got=%h required=%h", x.nm, obs, x.v);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    instr = 16'h0000;
    load  = 1'b0;
    s     = 1'b0;
    push(1, "reset", dn(0, 0, 16'h0000));
    tick();
    tick();
    reset = 1'b1;

    // ADD R2,R1,R0,LSL#1 with reset asserted during EXEC
    begin_run(16'hA148);
    push(e + 1, "rst_add_geta", ev(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0048));
    push(e + 2, "rst_add_getb", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0048));
    push(e + 4, "rst_add_wait", dn(0, 0, 16'h0000));
    end_issue();
    run_to(e + 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // MOV R0,#7: load first, then start separately
    instr = 16'hD007;
    load  = 1'b1;
    tick();
    load = 1'b0;
    s    = 1'b1;
    e    = cyc + 1;
    push(e + 1, "movimm_wr", ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 16'h0007));
    push(e + 2, "movimm_done", dn(0, 0, 16'h0007));
    tick();
    s = 1'b0;
    run_to(e + 2);

    // ADD R2,R1,R0,LSL#1
    begin_run(16'hA148);
    push(e + 1, "add_geta", ev(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0048));
    push(e + 2, "add_getb", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0048));
    push(e + 3, "add_exec", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 16'h0048));
    push(e + 4, "add_wr",   ev(0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0048));
    push(e + 5, "add_done", dn(0, 1, 16'h0048));
    end_issue();
    run_to(e + 5);

    // CMP R3,R0: status load only, no write
    begin_run(16'hAB80);
    push(e + 1, "cmp_geta", ev(0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'hFF80));
    push(e + 2, "cmp_getb", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'hFF80));
    push(e + 3, "cmp_exec", ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 16'hFF80));
    push(e + 4, "cmp_done", dn(0, 0, 16'hFF80));
    end_issue();
    run_to(e + 4);

    // MOV R0,#-128: negative immediate sign extension
    begin_run(16'hD080);
    push(e + 1, "movneg_wr", ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 16'hFF80));
    push(e + 2, "movneg_done", dn(0, 0, 16'hFF80));
    end_issue();
    run_to(e + 2);

    // Undefined opcode
    begin_run(16'hE000);
    push(e + 1, "illegal_done", dn(1, 0, 16'h0000));
    end_issue();
    run_to(e + 1);

    // MVN R7,R6 clears illegal in DECODE
    begin_run(16'hB8E6);
    push(e + 1, "mvn_getb", ev(0, 0, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'hFFE6));
    push(e + 2, "mvn_exec", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 16'hFFE6));
    push(e + 3, "mvn_wr",   ev(0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFE6));
    push(e + 4, "mvn_done", dn(0, 0, 16'hFFE6));
    end_issue();
    run_to(e + 4);

    // MOV R1,R2,LSR: shifted move forces ALU A operand to zero
    begin_run(16'hC032);
    push(e + 1, "movsh_getb", ev(0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 16'h0032));
    push(e + 2, "movsh_exec", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 16'h0032));
    push(e + 3, "movsh_wr",   ev(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 16'h0032));
    push(e + 4, "movsh_done", dn(0, 2, 16'h0032));
    end_issue();
    run_to(e + 4);

    // AND R3,R2,R1 with s held across two runs and a load attempt during GET_B
    begin_run(16'hB261);
    push(e + 1, "and1_geta", ev(0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0061));
    push(e + 2, "and1_getb", ev(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0061));
    push(e + 3, "and1_exec", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 16'h0061));
    push(e + 4, "and1_wr",   ev(0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0061));
    push(e + 5, "and1_done", dn(0, 0, 16'h0061));
    push(e + 7, "and2_geta", ev(0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0061));
    push(e + 8, "and2_getb", ev(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0061));
    push(e + 9, "and2_exec", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 16'h0061));
    push(e + 10, "and2_wr",  ev(0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0061));
    push(e + 11, "and2_done", dn(0, 0, 16'h0061));
    tick();
    load = 1'b0;
    run_to(e + 2);
    instr = 16'hD0FF;
    load  = 1'b1;
    tick();
    load = 1'b0;
    run_to(e + 6);
    s = 1'b0;
    run_to(e + 11);

    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0 first=%s", q.size(), q[0].nm);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
